count_seq_checker: RTL

Receive-side monitor for the 3-bit cyclic count stream 0,1,2,3,4,0,… produced by the counter FSM. Samples the stream on qualified cycles, hunts for the sequence start, acquires lock after a programmable number of clean frames, and flags every out-of-order or illegal value. Sits at the consuming end of the counter interface and provides lock status, per-event pulses and saturating statistics to downstream control and status logic.

---
 rtl/count_seq_checker.sv | 117 +++++++++++
 1 files changed

// File: rtl/count_seq_checker.sv
// Receive-side monitor for the cyclic 0..4 count stream: hunts for the start value,
// acquires lock after LOCK_N clean frames, and reports frame/error events and statistics.
module count_seq_checker #(
    parameter int LOCK_N = 2,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       din,
    input  logic             din_valid,
    input  logic             clr_stats,
    output logic             locked,
    output logic [2:0]       expected,
    output logic             frame_done,
    output logic             seq_err,
    output logic             illegal,
    output logic [CNT_W-1:0] frame_count,
    output logic [CNT_W-1:0] err_count
);

    typedef enum logic [1:0] {
        HUNT,
        ACQUIRE,
        LOCKED
    } state_t;

    state_t     state;
    logic [3:0] good_frames;

    logic       is_illegal;
    logic       match;
    logic       frame_inc;
    logic       err_inc;
    logic [2:0] expected_next;
    logic [3:0] good_inc;

    // NOTE: every signal gets a value on every path so no latch is inferred.
    always_comb begin
        is_illegal    = (din > 3'd4);
        match         = (din == expected);
        frame_inc     = din_valid && (state != HUNT) && match && (din == 3'd4);
        err_inc       = din_valid && (state != HUNT) && !match;
        expected_next = (expected == 3'd4) ? 3'd0 : expected + 3'd1;
        good_inc      = (good_frames == 4'd15) ? 4'd15 : good_frames + 4'd1;
    end

    // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= HUNT;
            good_frames <= 4'd0;
            locked      <= 1'b0;
            expected    <= 3'd0;
            frame_done  <= 1'b0;
            seq_err     <= 1'b0;
            illegal     <= 1'b0;
            frame_count <= '0;
            err_count   <= '0;
        end else begin
            frame_done <= 1'b0;
            seq_err    <= 1'b0;
            illegal    <= 1'b0;

            if (din_valid) begin
                illegal <= is_illegal;
                case (state)
                    HUNT: begin
                        // Anything other than the start value is discarded while hunting.
                        if (din == 3'd0) begin
                            state       <= ACQUIRE;
                            expected    <= 3'd1;
                            good_frames <= 4'd0;
                        end
                    end
                    default: begin
                        if (match) begin
                            expected <= expected_next;
                            if (din == 3'd4) begin
                                frame_done  <= 1'b1;
                                good_frames <= good_inc;
                                if (state == ACQUIRE && good_inc == 4'(LOCK_N)) begin
                                    state  <= LOCKED;
                                    locked <= 1'b1;
                                end
                            end
                        end else begin
                            seq_err     <= 1'b1;
                            good_frames <= 4'd0;
                            locked      <= 1'b0;
                            // A zero restarts a frame immediately; anything else drops back to hunting.
                            if (din == 3'd0) begin
                                state    <= ACQUIRE;
                                expected <= 3'd1;
                            end else begin
                                state    <= HUNT;
                                expected <= 3'd0;
                            end
                        end
                    end
                endcase
            end

            if (clr_stats) begin
                frame_count <= '0;
            end else if (frame_inc && frame_count != '1) begin
                frame_count <= frame_count + CNT_W'(1);
            end

            if (clr_stats) begin
                err_count <= '0;
            end else if (err_inc && err_count != '1) begin
                err_count <= err_count + CNT_W'(1);
            end
        end
    end

endmodule
